// File: rtl/instruction_ram_loader_if.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : instruction_ram_loader_if
// Description : Byte-stream handshake and instruction-RAM write bus used by
//               the boot loader.
//   byte_in                8            stream byte
//   byte_valid             1            byte_in is valid
//   byte_ready             1            loader accepts a byte this cycle
//   i_ram_writing_address  ADDRESS_WIDTH RAM write address
//   i_ram_input            32           RAM write data
//   flag_write_i_ram       1            RAM write enable
// Modports    : master = byte source / RAM observer, slave = loader
// Revision    : 1.0 - initial release
// ============================================================================
interface instruction_ram_loader_if #(
  parameter int ADDRESS_WIDTH = 10
);
  logic [7:0]               byte_in;
  logic                     byte_valid;
  logic                     byte_ready;
  logic [ADDRESS_WIDTH-1:0] i_ram_writing_address;
  logic [31:0]              i_ram_input;
  logic                     flag_write_i_ram;

  modport master (
    output byte_in, byte_valid,
    input  byte_ready, i_ram_writing_address, i_ram_input, flag_write_i_ram
  );

  modport slave (
    input  byte_in, byte_valid,
    output byte_ready, i_ram_writing_address, i_ram_input, flag_write_i_ram
  );
endinterface
`default_nettype wire

// File: rtl/instruction_ram_loader.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : instruction_ram_loader
// Description : Boot-time program loader. Parses a two-byte word-count
//               header, assembles big-endian 32-bit words from the byte
//               stream and writes them to the instruction RAM, holding the
//               CPU in halt while the load is in progress.
// Ports       :
//   clock          in   system clock, posedge
//   reset          in   synchronous active-low reset
//   start          in   load request, honoured only when idle
//   bus            slave byte stream + RAM write port
//   cpu_halt       out  processor stall during a load
//   load_done      out  one-cycle pulse on successful completion
//   load_error     out  sticky header-rejection flag
//   words_written  out  words written in the current / last load
// Revision    : 1.0 - initial release
// ============================================================================
module instruction_ram_loader #(
  parameter int ADDRESS_WIDTH = 10,
  parameter int MAX_WORDS     = 1024,
  parameter int BASE_ADDRESS  = 0
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     start,
  instruction_ram_loader_if.slave  bus,
  output logic                     cpu_halt,
  output logic                     load_done,
  output logic                     load_error,
  output logic [10:0]              words_written
);

  localparam logic [ADDRESS_WIDTH-1:0] BASE_AW = ADDRESS_WIDTH'(BASE_ADDRESS);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LEN_HI = 3'd1,
    ST_LEN_LO = 3'd2,
    ST_DATA   = 3'd3,
    ST_WRITE  = 3'd4,
    ST_DONE   = 3'd5
  } state_t;

  state_t      r_state;
  logic [10:0] r_count;
  logic [10:0] r_index;
  logic [1:0]  r_byte_cnt;
  // Only the first three bytes need storing; the fourth goes straight
  // into the write-data register.
  logic [23:0] r_assembly;

  logic                     w_xfer;
  logic [10:0]              w_hdr_count;
  logic                     w_hdr_bad;
  logic [10:0]              w_index_next;
  logic [ADDRESS_WIDTH-1:0] w_addr;

  assign w_xfer       = bus.byte_valid & bus.byte_ready;
  assign w_hdr_count  = {r_count[10:8], bus.byte_in};
  assign w_hdr_bad    = (w_hdr_count == 11'd0) || (int'(w_hdr_count) > MAX_WORDS);
  assign w_index_next = r_index + 11'd1;
  // Modular sum: addresses past the top of the RAM wrap silently.
  assign w_addr       = BASE_AW + ADDRESS_WIDTH'(r_index);

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state                   <= ST_IDLE;
      r_count                   <= '0;
      r_index                   <= '0;
      r_byte_cnt                <= '0;
      r_assembly                <= '0;
      bus.byte_ready            <= 1'b0;
      bus.i_ram_writing_address <= '0;
      bus.i_ram_input           <= '0;
      bus.flag_write_i_ram      <= 1'b0;
      cpu_halt                  <= 1'b0;
      load_done                 <= 1'b0;
      load_error                <= 1'b0;
      words_written             <= '0;
    end else begin
      load_done            <= 1'b0;
      bus.flag_write_i_ram <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_state        <= ST_LEN_HI;
            cpu_halt       <= 1'b1;
            load_error     <= 1'b0;
            words_written  <= '0;
            r_index        <= '0;
            r_count        <= '0;
            bus.byte_ready <= 1'b1;
          end
        end
        ST_LEN_HI: begin
          if (w_xfer) begin
            r_count[10:8] <= bus.byte_in[2:0];
            r_state       <= ST_LEN_LO;
          end
        end
        ST_LEN_LO: begin
          if (w_xfer) begin
            r_count[7:0] <= bus.byte_in;
            if (w_hdr_bad) begin
              load_error     <= 1'b1;
              cpu_halt       <= 1'b0;
              bus.byte_ready <= 1'b0;
              r_state        <= ST_IDLE;
            end else begin
              r_byte_cnt <= '0;
              r_state    <= ST_DATA;
            end
          end
        end
        ST_DATA: begin
          if (w_xfer) begin
            r_assembly <= {r_assembly[15:0], bus.byte_in};
            r_byte_cnt <= r_byte_cnt + 2'd1;
            if (r_byte_cnt == 2'd3) begin
              // Address and data are registered together with the flag so
              // all three are stable for the entire write cycle.
              bus.i_ram_input           <= {r_assembly, bus.byte_in};
              bus.i_ram_writing_address <= w_addr;
              bus.flag_write_i_ram      <= 1'b1;
              bus.byte_ready            <= 1'b0;
              r_state                   <= ST_WRITE;
            end
          end
        end
        ST_WRITE: begin
          r_index       <= w_index_next;
          words_written <= words_written + 11'd1;
          if (w_index_next == r_count) begin
            load_done <= 1'b1;
            cpu_halt  <= 1'b0;
            r_state   <= ST_DONE;
          end else begin
            bus.byte_ready <= 1'b1;
            r_state        <= ST_DATA;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state        <= ST_IDLE;
          bus.byte_ready <= 1'b0;
          cpu_halt       <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_instruction_ram_loader.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_instruction_ram_loader
// Description : Self-checking bench for instruction_ram_loader. Two loaders
//               (base 0 and base 1022) see the same stimulus; their write
//               streams are compared with a word-list reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instruction_ram_loader;
  localparam int AW = 10;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] byte_in = 8'd0;
  logic       byte_valid = 1'b0;

  always #5 clk = ~clk;

  instruction_ram_loader_if #(.ADDRESS_WIDTH(AW)) bus0 ();
  instruction_ram_loader_if #(.ADDRESS_WIDTH(AW)) bus1 ();
  assign bus0.byte_in    = byte_in;
  assign bus0.byte_valid = byte_valid;
  assign bus1.byte_in    = byte_in;
  assign bus1.byte_valid = byte_valid;

  logic        halt0, done0, err0, halt1, done1, err1;
  logic [10:0] ww0, ww1;

  instruction_ram_loader #(.ADDRESS_WIDTH(AW), .MAX_WORDS(1024), .BASE_ADDRESS(0)) dut0 (
    .clock(clk), .reset(rst_n), .start(start), .bus(bus0.slave),
    .cpu_halt(halt0), .load_done(done0), .load_error(err0), .words_written(ww0));

  instruction_ram_loader #(.ADDRESS_WIDTH(AW), .MAX_WORDS(1024), .BASE_ADDRESS(1022)) dut1 (
    .clock(clk), .reset(rst_n), .start(start), .bus(bus1.slave),
    .cpu_halt(halt1), .load_done(done1), .load_error(err1), .words_written(ww1));

  int checks = 0;
  int failures = 0;

  // Observed RAM writes {address, data} per loader.
  logic [AW+31:0] q0[$];
  logic [AW+31:0] q1[$];
  int  done_cnt0 = 0, done_cnt1 = 0, run_err = 0, halt_err = 0;
  bit  busy = 1'b0;
  bit  tog = 1'b0;
  logic pf0 = 1'b0, pf1 = 1'b0;
  logic [31:0] plan[$];

  always @(negedge clk) begin
    if (bus0.flag_write_i_ram) q0.push_back({bus0.i_ram_writing_address, bus0.i_ram_input});
    if (bus1.flag_write_i_ram) q1.push_back({bus1.i_ram_writing_address, bus1.i_ram_input});
    if (bus0.flag_write_i_ram && pf0) run_err++;
    if (bus1.flag_write_i_ram && pf1) run_err++;
    pf0 = bus0.flag_write_i_ram;
    pf1 = bus1.flag_write_i_ram;
    if (done0) done_cnt0++;
    if (done1) done_cnt1++;
    if (busy && !(halt0 && halt1) && !done0 && !err0) halt_err++;
    if (done0 || err0) busy = 1'b0;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit stall, input bit noise);
    bit sent = 1'b0;
    int n = 0;
    while (!sent && n < 100) begin
      @(negedge clk);
      byte_in    = b;
      tog        = ~tog;
      byte_valid = stall ? tog : 1'b1;
      start      = noise && ($urandom_range(0, 2) == 0);
      sent       = byte_valid && bus0.byte_ready;
      n++;
    end
    if (!sent) begin
      checks++;
      failures++;
      $error("FAIL send_timeout observed=%0d expected=accepted", n);
    end
  endtask

  task automatic run_load(input logic [7:0] hi, input logic [7:0] lo,
                          input bit stall, input bit noise, input string tag);
    int cnt;
    bit bad;
    int nbad0, nbad1;
    logic [31:0] words[$];
    logic [AW+31:0] e0, e1;
    cnt = int'({hi[2:0], lo});
    bad = (cnt == 0) || (cnt > 1024);
    q0.delete(); q1.delete();
    done_cnt0 = 0; done_cnt1 = 0; run_err = 0; halt_err = 0;
    @(negedge clk); start = 1'b1; byte_valid = 1'b0;
    @(negedge clk); start = 1'b0; busy = 1'b1;
    chk({tag, "_halt_after_start"}, 64'(halt0), 64'd1);
    chk({tag, "_err_cleared"}, 64'(err0), 64'd0);
    chk({tag, "_ww_cleared"}, 64'(ww0), 64'd0);
    send_byte(hi, stall, 1'b0);
    send_byte(lo, stall, 1'b0);
    if (bad) begin
      @(negedge clk); byte_valid = 1'b0;
      busy = 1'b0;
      chk({tag, "_err"}, 64'({err0, err1}), 64'b11);
      chk({tag, "_halt_released"}, 64'({halt0, halt1}), 64'b00);
      chk({tag, "_ready_low"}, 64'(bus0.byte_ready), 64'd0);
      repeat (3) @(negedge clk);
      chk({tag, "_no_writes"}, 64'(q0.size() + q1.size()), 64'd0);
      chk({tag, "_no_done"}, 64'(done_cnt0 + done_cnt1), 64'd0);
      return;
    end
    if (plan.size() == 0) begin
      for (int i = 0; i < cnt; i++) words.push_back($urandom);
    end else begin
      words = plan;
    end
    for (int i = 0; i < cnt; i++)
      for (int k = 0; k < 4; k++)
        send_byte(words[i][31-8*k -: 8], stall, noise);
    @(negedge clk); start = 1'b0; byte_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk({tag, "_done_pulses"}, 64'({done_cnt0[15:0], done_cnt1[15:0]}), {32'd0, 16'd1, 16'd1});
    chk({tag, "_write_count0"}, 64'(q0.size()), 64'(cnt));
    chk({tag, "_write_count1"}, 64'(q1.size()), 64'(cnt));
    nbad0 = 0; nbad1 = 0;
    for (int i = 0; i < cnt; i++) begin
      e0 = {AW'(i % 1024), words[i]};
      e1 = {AW'((1022 + i) % 1024), words[i]};
      if (cnt <= 8) begin
        chk($sformatf("%s_w0_%0d", tag, i), (i < q0.size()) ? 64'(q0[i]) : 64'hx, 64'(e0));
        chk($sformatf("%s_w1_%0d", tag, i), (i < q1.size()) ? 64'(q1[i]) : 64'hx, 64'(e1));
      end else begin
        if (i >= q0.size() || q0[i] !== e0) nbad0++;
        if (i >= q1.size() || q1[i] !== e1) nbad1++;
      end
    end
    if (cnt > 8) chk({tag, "_bad_words"}, 64'(nbad0 + nbad1), 64'd0);
    chk({tag, "_words_written"}, 64'({ww0, ww1}), 64'({11'(cnt), 11'(cnt)}));
    chk({tag, "_flag_single_cycle"}, 64'(run_err), 64'd0);
    chk({tag, "_halt_during_load"}, 64'(halt_err), 64'd0);
    chk({tag, "_idle_outputs"}, 64'({halt0, done0, err0, bus0.byte_ready}), 64'd0);
    busy = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_outputs", 64'({halt0, done0, err0, bus0.byte_ready, bus0.flag_write_i_ram}), 64'd0);
    chk("reset_bus", 64'({bus0.i_ram_writing_address, bus0.i_ram_input, ww0}), 64'd0);
    rst_n = 1'b1;

    plan = '{32'hDEADBEEF, 32'h01234567};
    run_load(8'h00, 8'h02, 1'b0, 1'b0, "basic");
    run_load(8'h00, 8'h02, 1'b1, 1'b0, "stalled");
    plan.delete();

    run_load(8'h00, 8'h00, 1'b0, 1'b0, "hdr_zero");
    run_load(8'h04, 8'h01, 1'b0, 1'b0, "hdr_1025");
    run_load(8'h00, 8'h03, 1'b0, 1'b0, "wrap3");
    run_load(8'h00, 8'h05, 1'b1, 1'b1, "start_noise");
    run_load(8'hF8, 8'h01, 1'b0, 1'b1, "hdr_high_bits");

    // Reset in the middle of the first word.
    q0.delete(); q1.delete();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    send_byte(8'h00, 1'b0, 1'b0);
    send_byte(8'h02, 1'b0, 1'b0);
    send_byte(8'hAB, 1'b0, 1'b0);
    send_byte(8'hCD, 1'b0, 1'b0);
    @(negedge clk); rst_n = 1'b0; byte_valid = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    chk("midreset_outputs", 64'({halt0, done0, err0, bus0.byte_ready, bus0.flag_write_i_ram, ww0}), 64'd0);
    chk("midreset_bus", 64'({bus0.i_ram_writing_address, bus0.i_ram_input}), 64'd0);
    repeat (3) @(negedge clk);
    chk("midreset_no_writes", 64'(q0.size() + q1.size()), 64'd0);
    run_load(8'h00, 8'h02, 1'b0, 1'b0, "after_reset");

    run_load(8'h04, 8'h00, 1'b0, 1'b0, "max_1024");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire
